// File: rtl/onehot_rr_arbiter.sv
// ---------------------------------------------------------------------------
// onehot_rr_arbiter
//
// Round-robin arbiter with a one-hot priority pointer and a bounded hold
// time. An owner keeps its grant while it requests. If other requesters are
// waiting and the owner has held the grant for MAXHOLD consecutive cycles,
// the grant is handed to the next requester and expire pulses for one cycle.
// A sole owner keeps its grant for as long as it requests; its hold counter
// saturates at MAXHOLD.
//
// Parameters
//   N        number of requesters (2..8)
//   MAXHOLD  maximum consecutive grant cycles while others wait (1..15)
//
// Ports
//   clock    rising-edge clock
//   reset    synchronous active-low reset
//   req      level request per requester
//   grant    registered grant, one-hot or all-zero
//   busy     registered, high whenever grant is non-zero
//   ptr      registered one-hot pointer: the first index searched
//   expire   registered one-cycle pulse on a forced (timeout) handoff
//
// States
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_IDLE    | no owner, grant = 0, hold counter = 0
//   S_GRANTED | one owner, grant = onehot(g), hold counter in 1..MAXHOLD
// ---------------------------------------------------------------------------
module onehot_rr_arbiter #(
    parameter int N       = 4,
    parameter int MAXHOLD = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         busy,
    output logic [N-1:0] ptr,
    output logic         expire
);

    localparam int HW = $clog2(MAXHOLD + 1);

    localparam logic [HW-1:0] HOLD_MAX  = HW'(MAXHOLD);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [N-1:0]  ONE_N     = N'(1);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_GRANTED = 1'b1
    } state_t;

    state_t         state_q,  state_d;
    logic [N-1:0]   grant_q,  grant_d;
    logic [N-1:0]   ptr_q,    ptr_d;
    logic [HW-1:0]  hold_q,   hold_d;
    logic           expire_q, expire_d;
    logic           busy_q;

    logic [N-1:0]   others;
    logic [N-1:0]   idle_pick;
    logic [N-1:0]   hand_pick;
    logic [N-1:0]   owner_next;
    logic           owner_req;

    // Rotate a one-hot vector one place towards the MSB, wrapping N-1 -> 0.
    function automatic logic [N-1:0] rotl(input logic [N-1:0] v);
        return {v[N-2:0], v[N-1]};
    endfunction

    // Cyclic first-set search starting at the one-hot position start_oh.
    // Bits at or above the start are tried first; if none of those is set
    // the search wraps and takes the lowest set bit overall. x & -x isolates
    // the lowest set bit of x. Returns all-zero when mask is empty.
    function automatic logic [N-1:0] pick_oh(input logic [N-1:0] mask,
                                             input logic [N-1:0] start_oh);
        logic [N-1:0] upper;
        logic [N-1:0] res;
        upper = mask & ~(start_oh - ONE_N);
        if (|upper) begin
            res = upper & (-upper);
        end else begin
            res = mask & (-mask);
        end
        return res;
    endfunction

    always_comb begin
        others     = req & ~grant_q;
        owner_req  = |(req & grant_q);
        idle_pick  = pick_oh(req, ptr_q);
        // In S_GRANTED the pointer already sits one past the owner, but the
        // handoff search is anchored on the owner itself so it never depends
        // on the pointer register being consistent with grant.
        owner_next = rotl(grant_q);
        hand_pick  = pick_oh(others, owner_next);

        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        expire_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_GRANTED;
                    grant_d = idle_pick;
                    ptr_d   = rotl(idle_pick);
                    hold_d  = HOLD_ONE;
                end
            end

            S_GRANTED: begin
                if (owner_req && (hold_q < HOLD_MAX)) begin
                    hold_d = hold_q + HOLD_ONE;
                end else if (|others) begin
                    // Release or timeout with someone waiting: hand off with
                    // no idle gap. Only a timeout (owner still requesting)
                    // counts as a forced handoff.
                    grant_d  = hand_pick;
                    ptr_d    = rotl(hand_pick);
                    hold_d   = HOLD_ONE;
                    expire_d = owner_req;
                end else if (!owner_req) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    ptr_d   = owner_next;
                    hold_d  = '0;
                end
                // Otherwise: sole owner past MAXHOLD, everything holds and
                // the counter stays saturated.
            end

            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                ptr_d   = ONE_N;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            ptr_q    <= ONE_N;
            hold_q   <= '0;
            expire_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            expire_q <= expire_d;
            busy_q   <= |grant_d;
        end
    end

    assign grant  = grant_q;
    assign ptr    = ptr_q;
    assign busy   = busy_q;
    assign expire = expire_q;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_onehot_rr_arbiter
//
// Bench for onehot_rr_arbiter with N=4, MAXHOLD=3. A table of directed
// vectors covers reset, the basic grant/handoff sequences, timeouts, pointer
// wrap and reset during a grant; short hand-written sequences cover the
// sole-requester saturation and same-cycle arrival cases; a long random run
// is compared against an index-based reference model.
// ---------------------------------------------------------------------------
module tb_onehot_rr_arbiter;

    localparam int N  = 4;
    localparam int MH = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic [3:0] grant;
    logic [3:0] ptr;
    logic       busy;
    logic       expire;

    always #5 clock = ~clock;

    onehot_rr_arbiter #(.N(N), .MAXHOLD(MH)) dut (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .grant  (grant),
        .busy   (busy),
        .ptr    (ptr),
        .expire (expire)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Apply inputs, take one rising edge, then sample 1 time unit later.
    task automatic step(input logic rb, input logic [3:0] r);
        reset = rb;
        req   = r;
        @(posedge clock);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g, input logic [3:0] p,
                              input logic b, input logic e);
        check({tag, ".grant"},  32'(grant),  32'(g));
        check({tag, ".ptr"},    32'(ptr),    32'(p));
        check({tag, ".busy"},   32'(busy),   32'(b));
        check({tag, ".expire"}, 32'(expire), 32'(e));
    endtask

    typedef struct packed {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] grant;
        logic [3:0] ptr;
        logic       busy;
        logic       expire;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic rb, input logic [3:0] r, input logic [3:0] g,
                       input logic [3:0] p, input logic b, input logic e);
        vec_t v;
        v.rst_n = rb; v.req = r; v.grant = g; v.ptr = p; v.busy = b; v.expire = e;
        tv.push_back(v);
    endtask

    // Reference model: owner/pointer kept as plain indices.
    int m_own  = -1;
    int m_ptr  = 0;
    int m_hold = 0;
    int m_exp  = 0;

    function automatic int scan(input int mask, input int start);
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (start + i) % N;
            if (((mask >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rb, input logic [3:0] r);
        int m;
        int others;
        int k;
        int owner;
        m = 32'(r);
        m_exp = 0;
        if (!rb) begin
            m_own = -1; m_ptr = 0; m_hold = 0;
            return;
        end
        if (m_own < 0) begin
            if (m != 0) begin
                k = scan(m, m_ptr);
                m_own = k; m_ptr = (k + 1) % N; m_hold = 1;
            end
        end else begin
            owner  = (m >> m_own) & 1;
            others = m & ~(1 << m_own);
            if (owner != 0 && m_hold < MH) begin
                m_hold++;
            end else if (others != 0) begin
                k = scan(others, (m_own + 1) % N);
                m_exp = owner;
                m_own = k; m_ptr = (k + 1) % N; m_hold = 1;
            end else if (owner == 0) begin
                m_ptr = (m_own + 1) % N; m_own = -1; m_hold = 0;
            end
        end
    endtask

    initial begin
        logic [3:0] r;
        logic       rb;
        int         sel;

        // rst_n req     grant    ptr      busy  expire
        add(1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b0); // reset
        add(1'b1, 4'b0101, 4'b0001, 4'b0010, 1'b1, 1'b0); // first grant
        add(1'b1, 4'b0100, 4'b0100, 4'b1000, 1'b1, 1'b0); // release, no gap
        add(1'b1, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b0); // idle, ptr=1000
        add(1'b1, 4'b1001, 4'b1000, 4'b0001, 1'b1, 1'b0); // wrap start
        add(1'b1, 4'b0001, 4'b0001, 4'b0010, 1'b1, 1'b0); // wrap handoff
        add(1'b1, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0);
        add(1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0); // reset
        add(1'b1, 4'b1111, 4'b0001, 4'b0010, 1'b1, 1'b0); // all requesting
        add(1'b1, 4'b1111, 4'b0001, 4'b0010, 1'b1, 1'b0);
        add(1'b1, 4'b1111, 4'b0001, 4'b0010, 1'b1, 1'b0);
        add(1'b1, 4'b1111, 4'b0010, 4'b0100, 1'b1, 1'b1); // timeout
        add(1'b1, 4'b1111, 4'b0010, 4'b0100, 1'b1, 1'b0);
        add(1'b1, 4'b1111, 4'b0010, 4'b0100, 1'b1, 1'b0);
        add(1'b1, 4'b1111, 4'b0100, 4'b1000, 1'b1, 1'b1); // timeout
        add(1'b1, 4'b1111, 4'b0100, 4'b1000, 1'b1, 1'b0);
        add(1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b0); // reset mid-grant
        add(1'b1, 4'b1111, 4'b0001, 4'b0010, 1'b1, 1'b0); // grant after reset

        foreach (tv[i]) begin
            step(tv[i].rst_n, tv[i].req);
            check_outs($sformatf("vec%0d", i), tv[i].grant, tv[i].ptr, tv[i].busy, tv[i].expire);
        end

        // Sole requester keeps the grant indefinitely without expiring.
        step(1'b1, 4'b0010);
        check_outs("sole_take", 4'b0010, 4'b0100, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'b0010);
            check_outs($sformatf("sole_hold%0d", i), 4'b0010, 4'b0100, 1'b1, 1'b0);
        end
        // A competitor appears after saturation: handoff on the next edge.
        step(1'b1, 4'b1010);
        check_outs("sat_handoff", 4'b1000, 4'b0001, 1'b1, 1'b1);
        step(1'b1, 4'b1010);
        check_outs("expire_once", 4'b1000, 4'b0001, 1'b1, 1'b0);

        // Owner releases while req[2] arrives and waiting req[1] drops.
        step(1'b1, 4'b0100);
        check_outs("same_cycle", 4'b0100, 4'b1000, 1'b1, 1'b0);
        step(1'b1, 4'b0000);
        check_outs("to_idle", 4'b0000, 4'b1000, 1'b0, 1'b0);

        // Random run against the reference model.
        r = 4'b0000;
        step(1'b0, r);
        model_step(1'b0, r);
        for (int c = 0; c < 3000; c++) begin
            sel = $urandom_range(0, 7);
            if (sel == 4 || sel == 5) r = r ^ 4'(1 << $urandom_range(0, 3));
            else if (sel == 6)        r = 4'($urandom_range(0, 15));
            else if (sel == 7)        r = 4'b0000;
            rb = ($urandom_range(0, 199) != 0);
            step(rb, r);
            model_step(rb, r);
            check("rnd.grant",  32'(grant),  (m_own < 0) ? 0 : (1 << m_own));
            check("rnd.ptr",    32'(ptr),    1 << m_ptr);
            check("rnd.busy",   32'(busy),   (m_own < 0) ? 0 : 1);
            check("rnd.expire", 32'(expire), m_exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
